// File: rtl/oam_dma_master.sv
// Sprite OAM DMA: snoops a CPU write to the DMA register, halts the CPU, then copies page $XX00-$XXFF to OAM.
// Optional OAM_DMA_ODD_ALIGN_EN inserts an ALIGN cycle when HALT ends on an odd CPU cycle (513/514-cycle timing).
module oam_dma_master #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic [15:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    input  logic        i_cpu_wn,
    output logic        o_cpu_rdy,
    output logic        o_bus_own,
    output logic [15:0] o_bus_addr,
    output logic [7:0]  o_bus_wdata,
    output logic        o_bus_wn,
    input  logic [7:0]  i_bus_rdata,
    output logic        o_dma_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_RD,
        S_WR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        par_q, par_d;

    logic        cpu_rdy_q, cpu_rdy_d;
    logic        bus_own_q, bus_own_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [7:0]  bus_wdata_q, bus_wdata_d;
    logic        bus_wn_q, bus_wn_d;
    logic        dma_busy_q, dma_busy_d;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;

        if (i_ce) begin
            par_d = ~par_q;
            case (state_q)
                S_IDLE: begin
                    if (!i_cpu_wn && (i_cpu_addr == DMA_REG_ADDR)) begin
                        state_d = S_HALT;
                        page_d  = i_cpu_wdata;
                        idx_d   = 8'h00;
                    end
                end
                S_HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
                    state_d = par_q ? S_ALIGN : S_RD;
`else
                    state_d = S_RD;
`endif
                end
                S_ALIGN: state_d = S_RD;
                S_RD: begin
                    state_d = S_WR;
                    data_d  = i_bus_rdata;
                end
                S_WR: begin
                    // A trigger landing on the final write is dropped: we go straight home.
                    if (idx_q == 8'hFF) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RD;
                        idx_d   = idx_q + 8'h01;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they can be registered alongside it.
        cpu_rdy_d   = 1'b1;
        bus_own_d   = 1'b0;
        bus_addr_d  = 16'h0000;
        bus_wdata_d = 8'h00;
        bus_wn_d    = 1'b1;
        dma_busy_d  = 1'b0;
        case (state_d)
            S_HALT, S_ALIGN: begin
                cpu_rdy_d  = 1'b0;
                dma_busy_d = 1'b1;
            end
            S_RD: begin
                cpu_rdy_d  = 1'b0;
                dma_busy_d = 1'b1;
                bus_own_d  = 1'b1;
                bus_addr_d = {page_d, idx_d};
            end
            S_WR: begin
                cpu_rdy_d   = 1'b0;
                dma_busy_d  = 1'b1;
                bus_own_d   = 1'b1;
                bus_addr_d  = OAM_DATA_ADDR;
                bus_wdata_d = data_d;
                bus_wn_d    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            page_q      <= 8'h00;
            idx_q       <= 8'h00;
            data_q      <= 8'h00;
            par_q       <= 1'b0;
            cpu_rdy_q   <= 1'b1;
            bus_own_q   <= 1'b0;
            bus_addr_q  <= 16'h0000;
            bus_wdata_q <= 8'h00;
            bus_wn_q    <= 1'b1;
            dma_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            par_q       <= par_d;
            cpu_rdy_q   <= cpu_rdy_d;
            bus_own_q   <= bus_own_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wn_q    <= bus_wn_d;
            dma_busy_q  <= dma_busy_d;
        end
    end

    assign o_cpu_rdy   = cpu_rdy_q;
    assign o_bus_own   = bus_own_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_wdata = bus_wdata_q;
    assign o_bus_wn    = bus_wn_q;
    assign o_dma_busy  = dma_busy_q;

endmodule

// File: tb/tb_oam_dma_master.sv
// Directed bench for oam_dma_master: transfer sequence, timing, ce gating, page $FF, reset and re-trigger.
module tb_oam_dma_master;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_ce;
    logic [15:0] i_cpu_addr;
    logic [7:0]  i_cpu_wdata;
    logic        i_cpu_wn;
    logic        o_cpu_rdy;
    logic        o_bus_own;
    logic [15:0] o_bus_addr;
    logic [7:0]  o_bus_wdata;
    logic        o_bus_wn;
    logic [7:0]  i_bus_rdata;
    logic        o_dma_busy;

    int n_checks = 0;
    int n_pass   = 0;
    bit tb_par   = 1'b0;

`ifdef OAM_DMA_ODD_ALIGN_EN
    localparam int LEN_ODD = 514;
`else
    localparam int LEN_ODD = 513;
`endif

    always #5 i_clk = ~i_clk;

    oam_dma_master dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ce        (i_ce),
        .i_cpu_addr  (i_cpu_addr),
        .i_cpu_wdata (i_cpu_wdata),
        .i_cpu_wn    (i_cpu_wn),
        .o_cpu_rdy   (o_cpu_rdy),
        .o_bus_own   (o_bus_own),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .o_bus_wn    (o_bus_wn),
        .i_bus_rdata (i_bus_rdata),
        .o_dma_busy  (o_dma_busy)
    );

    // Model memory contents: a fixed scramble of the address.
    function automatic logic [7:0] model_rd(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (lo * 8'd7) ^ a[15:8] ^ 8'h3C;
    endfunction

    always_comb begin
        i_bus_rdata = 8'h00;
        if (o_bus_own && o_bus_wn) i_bus_rdata = model_rd(o_bus_addr);
    end

    task automatic tick();
        if (i_rst) tb_par = 1'b0;
        else if (i_ce) tb_par = ~tb_par;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) $display("FAIL %s: got %0h want %0h", name, got, want);
        else n_pass++;
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_rdy"},   {31'd0, o_cpu_rdy},   32'd1);
        chk({name, "_own"},   {31'd0, o_bus_own},   32'd0);
        chk({name, "_addr"},  {16'd0, o_bus_addr},  32'd0);
        chk({name, "_wdata"}, {24'd0, o_bus_wdata}, 32'd0);
        chk({name, "_wn"},    {31'd0, o_bus_wn},    32'd1);
        chk({name, "_busy"},  {31'd0, o_dma_busy},  32'd0);
    endtask

    task automatic align_par(input bit want);
        i_ce     = 1'b1;
        i_cpu_wn = 1'b1;
        for (int k = 0; k < 2 && tb_par != want; k++) tick();
    endtask

    task automatic do_transfer(input logic [7:0] pg, input int period, input int exp_len,
                               input int inject_at, input int rst_at_wr, input string name);
        int pairs = 0, len = 0, addr_err = 0, wr_err = 0, frz_err = 0, cyc = 0;
        bit done = 1'b0, aborted = 1'b0, zero_hit = 1'b0, ce_now;
        logic [15:0] last_rd = 16'h0, first_bad = 16'h0;
        logic [7:0]  exp_dat = 8'h0, eidx = 8'h0;
        logic [27:0] cur, prev;

        i_cpu_addr  = 16'h4014;
        i_cpu_wdata = pg;
        i_cpu_wn    = 1'b0;
        i_ce        = 1'b1;
        tick();
        i_cpu_wn    = 1'b1;
        i_cpu_addr  = 16'h0100;
        i_cpu_wdata = 8'h00;
        chk({name, "_rdy_at_trigger"}, {31'd0, o_cpu_rdy}, 32'd0);
        len  = 1;
        prev = {o_cpu_rdy, o_bus_own, o_bus_addr, o_bus_wdata, o_bus_wn, o_dma_busy};

        while (!done && cyc < 3000) begin
            cyc++;
            i_ce = ((cyc % period) == 0);
            if (inject_at != 0 && cyc >= inject_at && cyc < inject_at + period) begin
                i_cpu_addr  = 16'h4014;
                i_cpu_wdata = 8'h05;
                i_cpu_wn    = 1'b0;
            end else begin
                i_cpu_addr  = 16'h0100;
                i_cpu_wdata = 8'h00;
                i_cpu_wn    = 1'b1;
            end
            ce_now = i_ce;
            tick();
            cur = {o_cpu_rdy, o_bus_own, o_bus_addr, o_bus_wdata, o_bus_wn, o_dma_busy};
            if (!ce_now) begin
                if (cur !== prev) frz_err++;
            end else begin
                if (o_cpu_rdy) done = 1'b1;
                else len++;
                if (o_bus_own && o_bus_addr == 16'h0000) zero_hit = 1'b1;
                if (o_bus_own && o_bus_wn) begin
                    if (o_bus_addr !== {pg, eidx}) begin
                        if (addr_err == 0) first_bad = o_bus_addr;
                        addr_err++;
                    end
                    last_rd = o_bus_addr;
                    exp_dat = model_rd({pg, eidx});
                end else if (o_bus_own) begin
                    if (o_bus_addr !== 16'h2004 || o_bus_wdata !== exp_dat) wr_err++;
                    pairs++;
                    eidx++;
                    if (rst_at_wr != 0 && pairs == rst_at_wr) begin
                        i_rst = 1'b1;
                        i_ce  = 1'b1;
                        tick();
                        check_idle_outputs({name, "_after_rst"});
                        i_rst   = 1'b0;
                        aborted = 1'b1;
                        done    = 1'b1;
                    end
                end
            end
            prev = cur;
        end
        i_ce     = 1'b1;
        i_cpu_wn = 1'b1;

        chk({name, "_completed_in_budget"}, {31'd0, done}, 32'd1);
        chk({name, "_rd_addr_errors"}, addr_err, 32'd0);
        if (addr_err != 0) $display("  %s first bad read address %04h", name, first_bad);
        chk({name, "_wr_errors"}, wr_err, 32'd0);
        chk({name, "_ce_freeze_errors"}, frz_err, 32'd0);
        if (!aborted) begin
            chk({name, "_pairs"}, pairs, 32'd256);
            chk({name, "_rdy_low_cycles"}, len, exp_len);
            chk({name, "_last_rd_addr"}, {16'd0, last_rd}, {16'd0, pg, 8'hFF});
            chk({name, "_no_access_0000"}, {31'd0, zero_hit}, 32'd0);
            chk({name, "_busy_end"}, {31'd0, o_dma_busy}, 32'd0);
        end else begin
            chk({name, "_wr_before_rst"}, pairs, rst_at_wr);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_ce = 1'b0;
        i_cpu_addr = 16'h0000;
        i_cpu_wdata = 8'h00;
        i_cpu_wn = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        i_rst = 1'b0;
    endtask

    task automatic test_basic();
        align_par(1'b1);
        do_transfer(8'h02, 1, 513, 0, 0, "page02_even");
    endtask

    task automatic test_odd_par();
        align_par(1'b0);
        do_transfer(8'h02, 1, LEN_ODD, 0, 0, "page02_odd");
    endtask

    task automatic test_ce_slow();
        align_par(1'b1);
        do_transfer(8'h02, 3, 513, 0, 0, "ce_1in3");
    endtask

    task automatic test_page_ff();
        align_par(1'b1);
        do_transfer(8'hFF, 1, 513, 0, 0, "page_ff");
    endtask

    task automatic test_reset_mid();
        align_par(1'b1);
        do_transfer(8'h02, 1, 513, 0, 100, "rst_mid");
        align_par(1'b1);
        do_transfer(8'h04, 1, 513, 0, 0, "after_rst");
    endtask

    task automatic test_inject();
        align_par(1'b1);
        do_transfer(8'h03, 1, 513, 200, 0, "inject");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_par();
        test_ce_slow();
        test_page_ff();
        test_reset_mid();
        test_inject();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_master.md
# oam_dma_master

Sprite OAM DMA engine for the NES console CPU bus. It detects a CPU write to $4014 and halts the CPU. It then takes ownership of the shared bus and copies 256 bytes from CPU page `$XX00–$XXFF` to the PPU OAM data port at $2004 as alternating read/write bus cycles. It acts as a bus initiator on the same address/data/write-strobe bus that the RAM and PPU adapters respond on, and it is muxed ahead of the CPU when it owns the bus.

## Interface
- `DMA_REG_ADDR`, default 16'h4014: trigger register address.
- `OAM_DATA_ADDR`, default 16'h2004: destination write address.
- `i_clk`  in  1: system clock.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_ce`  in  1: CPU-cycle enable; all state advances only when `i_ce=1`.
- `i_cpu_addr`  in  16: CPU bus address, snooped for the trigger write.
- `i_cpu_wdata`  in  8: CPU write data, which carries the page number.
- `i_cpu_wn`  in  1: CPU write strobe, active low.
- `o_cpu_rdy`  out  1: 0 halts the CPU.
- `o_bus_own`  out  1: 1 means the bus mux selects this block's outputs.
- `o_bus_addr`  out  16: initiator address.
- `o_bus_wdata`  out  8: initiator write data.
- `o_bus_wn`  out  1: initiator write strobe, active low.
- `i_bus_rdata`  in  8: read data returned by the responders.
- `o_dma_busy`  out  1: a transfer is in progress.

## Operation
- State register values: IDLE, HALT, ALIGN, RD, WR.
- Registers: 8-bit `page`, 8-bit `idx`, 8-bit `data` latch, 1-bit `par` (cycle parity).
- `par` toggles on every `i_ce` in every state, independent of the FSM.
- IDLE → HALT: on `i_ce` when `i_cpu_wn=0` and `i_cpu_addr==DMA_REG_ADDR`.
  - On the same `i_ce`: `page<=i_cpu_wdata` and `idx<=0`.
- HALT → ALIGN: on `i_ce` when `par==1` (see Configuration).
- HALT → RD: on `i_ce` otherwise.
- ALIGN → RD: on `i_ce`.
- RD → WR: on `i_ce`, with `data<=i_bus_rdata`.
- WR → RD: on `i_ce` when `idx!=8'hFF`, with `idx<=idx+1`.
- WR → IDLE: on `i_ce` when `idx==8'hFF`.
- Output decode from state:
  - IDLE: `o_bus_own=0`, `o_bus_addr=16'h0`, `o_bus_wdata=8'h0`, `o_bus_wn=1`, `o_cpu_rdy=1`, `o_dma_busy=0`.
  - HALT and ALIGN: `o_cpu_rdy=0`, `o_dma_busy=1`, `o_bus_own=0`, bus outputs at idle values.
  - RD: `o_bus_own=1`, `o_bus_addr={page,idx}`, `o_bus_wn=1`, `o_bus_wdata=8'h0`.
  - WR: `o_bus_own=1`, `o_bus_addr=OAM_DATA_ADDR`, `o_bus_wdata=data`, `o_bus_wn=0`.
- Address arithmetic: `idx` is 8 bits. Source addresses stay inside the page, so page $FF reads $FF00–$FFFF and never wraps into $0000.
- Trigger writes that arrive while not in IDLE are ignored. `page` and `idx` are not modified.
- A trigger coinciding with the final WR `i_ce` is also ignored. The FSM returns to IDLE.
- Reads during DMA go through the normal address decode, so page $00–$1F mirrors into RAM via the responder.

## Timing
- All outputs are pure decodes of registered state. There is no combinational path from any input to any output.
- Trigger `i_ce` at clock edge N: `o_cpu_rdy=0` from edge N onward.
- Transfer length, counted in `i_ce` cycles from HALT entry to IDLE re-entry: 513 when `par==0` at HALT exit, 514 when `par==1` (macro defined).
- `i_bus_rdata` is sampled at the `i_ce` edge that ends RD. The responder must return data within the same CPU cycle.
- `i_ce=0` freezes the FSM, `idx`, `data` and `par`. Outputs hold their values.
- Reset, at any time including mid-transfer: on the next edge the FSM goes to IDLE and `page`, `idx`, `data`, `par` clear to 0. All outputs take their IDLE values. No partial write completes after reset.

## Configuration
- `OAM_DMA_ODD_ALIGN_EN`
  - Defined: the HALT→ALIGN branch is present, giving 513/514-cycle accurate timing.
  - Undefined: HALT always goes to RD, ALIGN is unreachable and may be omitted, and every transfer is exactly 513 `i_ce` cycles.

## Test plan
- Trigger with `i_cpu_wdata=8'h02` and `par=0`, `i_ce` held at 1:
  - exactly 256 RD/WR pairs;
  - RD addresses run $0200 through $02FF;
  - WR data equals the model RAM contents in order, with address $2004;
  - `o_cpu_rdy` is low for exactly 513 cycles.
- Same trigger with `par=1`: 514 cycles with the macro defined, 513 without.
- `i_ce` toggled 1-in-3: the same address/data sequence, and no state change on `i_ce=0` edges.
- Page $FF: the last read is at $FFFF, followed by IDLE, with no access at $0000.
- `i_rst` asserted after the 100th WR: all outputs at IDLE values the next edge and `o_cpu_rdy=1`. A new trigger then restarts from `idx=0`.
- A $4014 write with data $05 injected mid-transfer from page $03: ignored, and all reads stay in $03xx.
